// File: rtl/uxa_ps2_busctl_mc.sv
// Wishbone decode into 2**CHAN_W PS/2 channels with open-drain enables and FIFO pop strobes;
// zero wait states (ack = stb); optional clock-inhibit auto-release timer via UXA_PS2_AUTORELEASE_EN.
module uxa_ps2_busctl_mc #(
  parameter int CHAN_W      = 1,
  parameter int HOLD_W      = 12,
  parameter int HOLD_CYCLES = 2500
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_reset_i,
  input  logic [CHAN_W-1:0]      wb_adr_i,
  input  logic                   wb_we_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_dat_8_i,
  input  logic                   wb_dat_9_i,
  output logic                   wb_ack_o,
  output logic [1:0]             wb_dat_o,
  output logic [2**CHAN_W-1:0]   rp_inc_o,
  output logic [2**CHAN_W-1:0]   c_oe_o,
  output logic [2**CHAN_W-1:0]   d_oe_o
);

  localparam int NCH = 2**CHAN_W;

  logic [NCH-1:0] c_oe_q, c_oe_d;
  logic [NCH-1:0] d_oe_q, d_oe_d;
  logic [NCH-1:0] rp_inc_q, rp_inc_d;
  logic [NCH-1:0] wr_hit;

`ifdef UXA_PS2_AUTORELEASE_EN
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt_q [NCH];
  logic [HOLD_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]    armed_q, armed_d;
`endif

  assign wb_ack_o = wb_stb_i;
  assign wb_dat_o = (wb_stb_i & ~wb_we_i) ? {d_oe_q[wb_adr_i], c_oe_q[wb_adr_i]} : 2'b00;
  assign rp_inc_o = rp_inc_q;
  assign c_oe_o   = c_oe_q;
  assign d_oe_o   = d_oe_q;

  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      wr_hit[k] = wb_stb_i & wb_we_i & (wb_adr_i == CHAN_W'(k));
    end
  end

  always_comb begin
    c_oe_d   = c_oe_q;
    d_oe_d   = d_oe_q;
    rp_inc_d = wr_hit;
`ifdef UXA_PS2_AUTORELEASE_EN
    cnt_d    = cnt_q;
    armed_d  = armed_q;
`endif
    for (int k = 0; k < NCH; k++) begin
`ifdef UXA_PS2_AUTORELEASE_EN
      if (armed_q[k]) begin
        if (cnt_q[k] != '0) begin
          cnt_d[k] = cnt_q[k] - HOLD_W'(1);
        end else begin
          c_oe_d[k]  = 1'b0;
          armed_d[k] = 1'b0;
        end
      end
`endif
      // A write in the expiry cycle overrides the release decided above.
      if (wr_hit[k]) begin
        c_oe_d[k] = ~wb_dat_8_i;
        d_oe_d[k] = ~wb_dat_9_i;
`ifdef UXA_PS2_AUTORELEASE_EN
        armed_d[k] = ~wb_dat_8_i;
        if (~wb_dat_8_i) begin
          cnt_d[k] = HOLD_LOAD;
        end
`endif
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_reset_i) begin
    if (!sys_reset_i) begin
      c_oe_q   <= '0;
      d_oe_q   <= '0;
      rp_inc_q <= '0;
`ifdef UXA_PS2_AUTORELEASE_EN
      armed_q  <= '0;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
`endif
    end else begin
      c_oe_q   <= c_oe_d;
      d_oe_q   <= d_oe_d;
      rp_inc_q <= rp_inc_d;
`ifdef UXA_PS2_AUTORELEASE_EN
      armed_q  <= armed_d;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
`endif
    end
  end

endmodule

// File: tb/tb_uxa_ps2_busctl_mc.sv
// Directed bench for uxa_ps2_busctl_mc (CHAN_W=1, HOLD_CYCLES=4) with a queue-based scoreboard.
module tb_uxa_ps2_busctl_mc;

`ifdef UXA_PS2_AUTORELEASE_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  // Channel-0 clock enable after auto-release has (or would have) fired.
  localparam logic [1:0] C_REL = AR ? 2'b00 : 2'b01;

  logic       clk;
  logic       rst_n;
  logic [0:0] adr;
  logic       we, stb, d8, d9;
  logic       ack;
  logic [1:0] dat, rp, coe, doe;

  uxa_ps2_busctl_mc #(.CHAN_W(1), .HOLD_W(12), .HOLD_CYCLES(4)) dut (
    .sys_clk_i   (clk),
    .sys_reset_i (rst_n),
    .wb_adr_i    (adr),
    .wb_we_i     (we),
    .wb_stb_i    (stb),
    .wb_dat_8_i  (d8),
    .wb_dat_9_i  (d9),
    .wb_ack_o    (ack),
    .wb_dat_o    (dat),
    .rp_inc_o    (rp),
    .c_oe_o      (coe),
    .d_oe_o      (doe)
  );

  typedef struct {
    int         id;
    logic [1:0] c;
    logic [1:0] d;
    logic [1:0] r;
    logic       a;
    logic [1:0] dt;
    bit         chk_dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   vec_id   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got {c,d,rp,ack,dat}=%b required %b", nm, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("vec%0d", e.id),
            {coe, doe, rp, ack, e.chk_dat ? dat : 2'b00},
            {e.c, e.d, e.r, e.a, e.chk_dat ? e.dt : 2'b00});
      end
    end
  end

  // One bus cycle: drive inputs after the edge and queue the outputs expected in this cycle.
  task automatic step(input logic s, input logic w, input logic a, input logic v8, input logic v9,
                      input logic [1:0] ec, input logic [1:0] ed, input logic [1:0] er,
                      input logic [1:0] edt, input bit cd);
    exp_t e;
    @(posedge clk);
    #1;
    stb = s; we = w; adr = a; d8 = v8; d9 = v9;
    vec_id++;
    e.id = vec_id; e.c = ec; e.d = ed; e.r = er; e.a = s; e.dt = edt; e.chk_dat = cd;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [1:0] ec, input logic [1:0] ed, input logic [1:0] er);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ec, ed, er, 2'b00, 1'b1);
  endtask

  task automatic wr(input logic a, input logic v8, input logic v9,
                    input logic [1:0] ec, input logic [1:0] ed, input logic [1:0] er);
    step(1'b1, 1'b1, a, v8, v9, ec, ed, er, 2'b00, 1'b0);
  endtask

  task automatic rd(input logic a, input logic [1:0] ec, input logic [1:0] ed,
                    input logic [1:0] er, input logic [1:0] edt);
    step(1'b1, 1'b0, a, 1'b1, 1'b1, ec, ed, er, edt, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; adr = 1'b0; d8 = 1'b1; d9 = 1'b1;
    #2;
    chk("reset_init", {coe, doe, rp, ack, dat}, 9'b0);
    #10 rst_n = 1'b1;

    rd(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);        // 1 read ch1, no side effects
    idle(2'b00, 2'b00, 2'b00);
    idle(2'b00, 2'b00, 2'b00);
    wr(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);   // 4 write ch0, pull both low
    idle(2'b01, 2'b01, 2'b01);
    idle(2'b01, 2'b01, 2'b00);
    rd(1'b0, 2'b01, 2'b01, 2'b00, 2'b11);        // 7 read back ch0
    idle(2'b01, 2'b01, 2'b00);
    idle(C_REL, 2'b01, 2'b00);                   // 9 released after 4 cycles
    idle(C_REL, 2'b01, 2'b00);
    wr(1'b1, 1'b1, 1'b0, C_REL, 2'b01, 2'b00);   // 11 back-to-back ch1
    wr(1'b1, 1'b1, 1'b1, C_REL, 2'b11, 2'b10);
    idle(C_REL, 2'b01, 2'b10);
    idle(C_REL, 2'b01, 2'b00);
    wr(1'b0, 1'b0, 1'b0, C_REL, 2'b01, 2'b00);   // 15 retrigger test
    idle(2'b01, 2'b01, 2'b01);
    idle(2'b01, 2'b01, 2'b00);
    wr(1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00);   // 18 second write at cycle 3
    idle(2'b01, 2'b01, 2'b01);
    idle(2'b01, 2'b01, 2'b00);
    idle(2'b01, 2'b01, 2'b00);
    idle(2'b01, 2'b01, 2'b00);
    idle(C_REL, 2'b01, 2'b00);                   // 23
    wr(1'b0, 1'b1, 1'b1, C_REL, 2'b01, 2'b00);   // 24 explicit release
    idle(2'b00, 2'b00, 2'b01);
    wr(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);   // 26 clock only
    idle(2'b01, 2'b00, 2'b01);
    idle(2'b01, 2'b00, 2'b00);
    idle(2'b01, 2'b00, 2'b00);
    wr(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00);   // 30 write on expiry edge wins
    idle(2'b01, 2'b00, 2'b01);
    idle(2'b01, 2'b00, 2'b00);
    idle(2'b01, 2'b00, 2'b00);
    idle(2'b01, 2'b00, 2'b00);
    idle(C_REL, 2'b00, 2'b00);                   // 35
    wr(1'b1, 1'b0, 1'b0, C_REL, 2'b00, 2'b00);   // 36 load ch1 before reset
    rd(1'b1, C_REL | 2'b10, 2'b10, 2'b10, 2'b11);

    @(negedge clk);
    #2;
    stb = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_mid", {coe, doe, rp, ack, dat}, 9'b0);
    #1 rst_n = 1'b1;

    idle(2'b00, 2'b00, 2'b00);
    rd(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    idle(2'b00, 2'b00, 2'b00);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uxa_ps2_busctl_mc.md
# uxa_ps2_busctl_mc

Multi-channel Wishbone bus controller for the UXA PS/2 ports, successor to the single-port bus controller. It decodes one zero-wait-state Wishbone slave into 2**CHAN_W independent PS/2 channels. Each channel has registered clock/data open-drain output enables and a one-cycle receive-FIFO pop strobe. An optional per-channel auto-release timer implements the host request-to-send clock-inhibit pulse in hardware.

## Interface
- CHAN_W, 1, channel-select width; channel count NCH = 2**CHAN_W.
- HOLD_W, 12, auto-release counter width.
- HOLD_CYCLES, 2500, clock-inhibit length in sys_clk cycles (100 µs at 25 MHz); legal range 1 to 2**HOLD_W-1.

Ports:
- sys_clk_i  in  1  system clock, all state on rising edge.
- sys_reset_i  in  1  reset; asynchronous, active-low.
- wb_adr_i  in  CHAN_W  channel select.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_stb_i  in  1  cycle strobe.
- wb_dat_8_i  in  1  written clock line level (0 = pull low).
- wb_dat_9_i  in  1  written data line level (0 = pull low).
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  2  read-back {d_oe, c_oe} of the selected channel.
- rp_inc_o  out  NCH  per-channel receive-FIFO pop strobe.
- c_oe_o  out  NCH  per-channel clock driver enable (1 = drive low).
- d_oe_o  out  NCH  per-channel data driver enable (1 = drive low).

## Operation
- wb_ack_o = wb_stb_i, combinational. Every strobed cycle completes in one clock; there are no wait states.
- Accepted write: a rising edge with wb_stb_i & wb_we_i. Channel k = wb_adr_i.
  - c_oe_o[k] <= ~wb_dat_8_i.
  - d_oe_o[k] <= ~wb_dat_9_i.
  - rp_inc_o[k] <= 1.
  - All other channels are unchanged.
- rp_inc_o[j] <= 0 on every edge without an accepted write to channel j. Each accepted write therefore produces exactly one high cycle. N back-to-back writes to one channel hold rp_inc_o high for exactly N cycles.
- Read (wb_stb_i & ~wb_we_i): wb_dat_o = {d_oe_o[k], c_oe_o[k]}, combinational. A read has no side effects: no rp_inc and no enable change.
- wb_dat_o is 0 when wb_stb_i is 0.
- Auto-release (only when the feature is compiled in), per channel: counter cnt[k] of HOLD_W bits, plus an armed flag.
  - A write that sets c_oe_o[k]=1 loads cnt[k]=HOLD_CYCLES-1 and arms it.
  - Armed and cnt[k]!=0: decrement by 1 each cycle.
  - Armed and cnt[k]==0: clear c_oe_o[k] and disarm. d_oe_o[k] is untouched, so data stays low for the request-to-send.
  - A write with c_oe=0 disarms.
  - A write arriving in the same cycle as expiry wins: it reloads or disarms, and the expiry is discarded.
- Channels operate fully independently; simultaneous expiries on several channels are all honoured.

## Timing
- Reset (sys_reset_i low, asynchronous, including mid-transfer or mid-inhibit) clears immediately:
  - c_oe_o, d_oe_o, rp_inc_o.
  - All counters to 0, disarmed.
  - wb_dat_o follows its combinational rule. wb_ack_o follows wb_stb_i.
- Write latency: enables and rp_inc_o change at the same rising edge that samples the write, and are visible in the following cycle.
- Auto-release: c_oe_o[k] is high for exactly HOLD_CYCLES cycles after the write edge. With HOLD_CYCLES=1, it is high for one cycle.
- Counter arithmetic is unsigned, HOLD_W bits. It never wraps, because an armed counter at 0 always disarms.

## Configuration
- UXA_PS2_AUTORELEASE_EN defined: per-channel timers are built and behave as in Operation.
- UXA_PS2_AUTORELEASE_EN undefined: no counters. c_oe_o[k] changes only on writes. HOLD_W and HOLD_CYCLES are ignored.

## Test plan
- Reset: pulse sys_reset_i low mid-clock with stb/we/dat idle -> c_oe_o=0, d_oe_o=0, rp_inc_o=0, wb_ack_o=0 before the next edge.
- Read, ch 1 (CHAN_W=1): wb_stb_i=1, wb_we_i=0, adr=1 -> wb_ack_o=1 in the same cycle, wb_dat_o=2'b00, rp_inc_o=2'b00 for the following 2 cycles.
- Write, ch 0: dat_8=0, dat_9=0 for one cycle -> next cycle c_oe_o=2'b01, d_oe_o=2'b01, rp_inc_o=2'b01 for exactly one cycle, channel 1 untouched.
- Back-to-back: 2 consecutive writes to ch 1 -> rp_inc_o[1] high for exactly 2 cycles, then 0; rp_inc_o[0] stays 0 throughout.
- Auto-release (macro on, HOLD_CYCLES=4): write ch 0 with dat_8=0, dat_9=0 -> c_oe_o[0] high for 4 cycles then 0, d_oe_o[0] stays 1. Repeat with a second write at cycle 3 -> c_oe_o[0] high for 4 cycles from the second write.
- Macro off, same stimulus -> c_oe_o[0] stays 1 until a write with dat_8=1.
